// File: rtl/ld_stream_split.sv
// ld_stream_split
// Accepts one tile's load configuration, then steers a single AXI-Stream
// of packed load beats into the loader interface. The first act_times
// beats become activation beats. The following bs+bp beats become weight
// beats. After the last beat the block waits for the load controller's
// ld_tile_end and then pulses tile_done upstream.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   cfg_*                  tile configuration handshake and counts
//   s_axis_*               incoming load-beat stream
//   bw_act_times,
//   bs_bw_wgt_times,
//   bp_bw_wgt_times        latched counts for the load controller
//   ld_tile_start          one-cycle pulse at tile start
//   ld_valid_act/_wgt      registered beat qualifiers for ld_data
//   ld_data                registered beat
//   ld_tile_end            load controller completion
//   tile_done              one-cycle completion pulse upstream
//   err_cfg, err_tlast     sticky error flags, cleared only by rst
module ld_stream_split #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_act_times,
  input  logic [15:0]       cfg_bs_wgt_times,
  input  logic [15:0]       cfg_bp_wgt_times,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [15:0]       bw_act_times,
  output logic [15:0]       bs_bw_wgt_times,
  output logic [15:0]       bp_bw_wgt_times,
  output logic              ld_tile_start,
  output logic              ld_valid_act,
  output logic              ld_valid_wgt,
  output logic [DATA_W-1:0] ld_data,
  input  logic              ld_tile_end,
  output logic              tile_done,
  output logic              err_cfg,
  output logic              err_tlast
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACT,
    WGT,
    WAIT_END
  } state_t;

  state_t            state_reg;
  logic [16:0]       beat_cnt_reg;
  logic [16:0]       wgt_total_reg;
  logic [15:0]       act_times_reg;
  logic [15:0]       bs_times_reg;
  logic [15:0]       bp_times_reg;
  logic              tile_start_reg;
  logic              valid_act_reg;
  logic              valid_wgt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              tile_done_reg;
  logic              err_cfg_reg;
  logic              err_tlast_reg;

  logic beat_fire;
  logic act_last;
  logic wgt_last;
  logic cfg_zero;

  // Ready signals are decoded from state so that a reset edge drops them
  // immediately and cfg_ready comes up in the first cycle after reset.
  assign cfg_ready     = (state_reg == IDLE) && !rst;
  assign s_axis_tready = (state_reg == ACT) || (state_reg == WGT);

  assign beat_fire = s_axis_tvalid && s_axis_tready;

  // The counter is 17 bits wide so that the weight phase (bs+bp) fits.
  // The activation compare zero-extends the 16-bit count.
  assign act_last = (beat_cnt_reg == ({1'b0, act_times_reg} - 17'd1));
  assign wgt_last = (beat_cnt_reg == (wgt_total_reg - 17'd1));

  // Zero counts would wrap the load controller's times-1 compare.
  assign cfg_zero = (cfg_act_times == 16'd0) || (cfg_bs_wgt_times == 16'd0) ||
                    (cfg_bp_wgt_times == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= '0;
      wgt_total_reg  <= '0;
      act_times_reg  <= '0;
      bs_times_reg   <= '0;
      bp_times_reg   <= '0;
      tile_start_reg <= 1'b0;
      valid_act_reg  <= 1'b0;
      valid_wgt_reg  <= 1'b0;
      data_reg       <= '0;
      tile_done_reg  <= 1'b0;
      err_cfg_reg    <= 1'b0;
      err_tlast_reg  <= 1'b0;
    end else begin
      tile_start_reg <= 1'b0;
      valid_act_reg  <= 1'b0;
      valid_wgt_reg  <= 1'b0;
      tile_done_reg  <= 1'b0;

      if (beat_fire) begin
        data_reg      <= s_axis_tdata;
        valid_act_reg <= (state_reg == ACT);
        valid_wgt_reg <= (state_reg == WGT);
        // tlast belongs exactly on the final weight beat. A mismatch is
        // only flagged; the beat counts still drive the phase changes.
        if (s_axis_tlast != ((state_reg == WGT) && wgt_last)) begin
          err_tlast_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_zero) begin
              err_cfg_reg <= 1'b1;
            end else begin
              act_times_reg  <= cfg_act_times;
              bs_times_reg   <= cfg_bs_wgt_times;
              bp_times_reg   <= cfg_bp_wgt_times;
              wgt_total_reg  <= {1'b0, cfg_bs_wgt_times} + {1'b0, cfg_bp_wgt_times};
              beat_cnt_reg   <= '0;
              tile_start_reg <= 1'b1;
              state_reg      <= START;
            end
          end
        end
        START: begin
          state_reg <= ACT;
        end
        ACT: begin
          if (beat_fire) begin
            if (act_last) begin
              beat_cnt_reg <= '0;
              state_reg    <= WGT;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 17'd1;
            end
          end
        end
        WGT: begin
          if (beat_fire) begin
            if (wgt_last) begin
              state_reg <= WAIT_END;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 17'd1;
            end
          end
        end
        WAIT_END: begin
          if (ld_tile_end) begin
            tile_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bw_act_times    = act_times_reg;
  assign bs_bw_wgt_times = bs_times_reg;
  assign bp_bw_wgt_times = bp_times_reg;
  assign ld_tile_start   = tile_start_reg;
  assign ld_valid_act    = valid_act_reg;
  assign ld_valid_wgt    = valid_wgt_reg;
  assign ld_data         = data_reg;
  assign tile_done       = tile_done_reg;
  assign err_cfg         = err_cfg_reg;
  assign err_tlast       = err_tlast_reg;

endmodule

// File: tb/tb_ld_stream_split.sv
module tb_ld_stream_split;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [15:0]       cfg_act_times = '0;
  logic [15:0]       cfg_bs_wgt_times = '0;
  logic [15:0]       cfg_bp_wgt_times = '0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [15:0]       bw_act_times;
  logic [15:0]       bs_bw_wgt_times;
  logic [15:0]       bp_bw_wgt_times;
  logic              ld_tile_start;
  logic              ld_valid_act;
  logic              ld_valid_wgt;
  logic [DATA_W-1:0] ld_data;
  logic              ld_tile_end = 1'b0;
  logic              tile_done;
  logic              err_cfg;
  logic              err_tlast;

  int checks = 0;
  int errors = 0;

  ld_stream_split #(.DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_act_times   (cfg_act_times),
    .cfg_bs_wgt_times(cfg_bs_wgt_times),
    .cfg_bp_wgt_times(cfg_bp_wgt_times),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .bw_act_times    (bw_act_times),
    .bs_bw_wgt_times (bs_bw_wgt_times),
    .bp_bw_wgt_times (bp_bw_wgt_times),
    .ld_tile_start   (ld_tile_start),
    .ld_valid_act    (ld_valid_act),
    .ld_valid_wgt    (ld_valid_wgt),
    .ld_data         (ld_data),
    .ld_tile_end     (ld_tile_end),
    .tile_done       (tile_done),
    .err_cfg         (err_cfg),
    .err_tlast       (err_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a tile is either absent, in its start cycle, or
  // busy with k of total beats accepted. Expected outputs for the
  // current cycle are held in e_* and advanced once per cycle.
  bit          chk_en = 0;
  bit          m_busy = 0;
  int          m_k = 0;
  int          m_act = 0;
  int          m_total = 0;
  bit          e_start = 0;
  bit          e_va = 0;
  bit          e_vw = 0;
  bit          e_done = 0;
  bit          e_ecfg = 0;
  bit          e_etl = 0;
  logic [15:0] e_at = '0;
  logic [15:0] e_bs = '0;
  logic [15:0] e_bp = '0;
  logic [63:0] e_data = '0;

  int n_act = 0;
  int n_wgt = 0;
  int n_start = 0;
  int n_done = 0;

  always @(negedge clk) begin
    bit streaming;
    bit waiting;
    streaming = m_busy && !e_start && (m_k < m_total);
    waiting   = m_busy && !e_start && (m_k == m_total);

    if (chk_en) begin
      chk("cfg_ready", cfg_ready, !m_busy && !rst);
      chk("tready", s_axis_tready, streaming);
      chk("ld_tile_start", ld_tile_start, e_start);
      chk("ld_valid_act", ld_valid_act, e_va);
      chk("ld_valid_wgt", ld_valid_wgt, e_vw);
      chk("ld_data", ld_data, e_data);
      chk("tile_done", tile_done, e_done);
      chk("err_cfg", err_cfg, e_ecfg);
      chk("err_tlast", err_tlast, e_etl);
      chk("bw_act_times", bw_act_times, e_at);
      chk("bs_bw_wgt_times", bs_bw_wgt_times, e_bs);
      chk("bp_bw_wgt_times", bp_bw_wgt_times, e_bp);
      if (ld_valid_act && ld_valid_wgt) chk("valid_exclusive", 1'b1, 1'b0);
    end

    if (ld_valid_act) n_act++;
    if (ld_valid_wgt) n_wgt++;
    if (ld_tile_start) n_start++;
    if (tile_done) n_done++;

    if (rst) begin
      chk_en = 1;
      m_busy = 0; m_k = 0; m_act = 0; m_total = 0;
      e_start = 0; e_va = 0; e_vw = 0; e_done = 0; e_ecfg = 0; e_etl = 0;
      e_at = '0; e_bs = '0; e_bp = '0; e_data = '0;
    end else begin
      e_start = 0; e_va = 0; e_vw = 0; e_done = 0;
      if (!m_busy && cfg_valid) begin
        if (cfg_act_times == 0 || cfg_bs_wgt_times == 0 || cfg_bp_wgt_times == 0) begin
          e_ecfg = 1;
        end else begin
          e_at = cfg_act_times; e_bs = cfg_bs_wgt_times; e_bp = cfg_bp_wgt_times;
          m_act   = int'(cfg_act_times);
          m_total = int'(cfg_act_times) + int'(cfg_bs_wgt_times) + int'(cfg_bp_wgt_times);
          m_k = 0; m_busy = 1; e_start = 1;
        end
      end else if (streaming && s_axis_tvalid) begin
        e_data = s_axis_tdata;
        e_va = (m_k < m_act);
        e_vw = !(m_k < m_act);
        if (s_axis_tlast != (m_k == m_total - 1)) e_etl = 1;
        m_k++;
      end else if (waiting && ld_tile_end) begin
        m_busy = 0;
        e_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int a, input int b, input int c);
    bit got;
    got = 0;
    cfg_act_times = a[15:0]; cfg_bs_wgt_times = b[15:0]; cfg_bp_wgt_times = c[15:0];
    cfg_valid = 1;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      got = cfg_ready;
      tick();
    end
    cfg_valid = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL cfg_timeout: got no handshake expected cfg_ready within 50 cycles");
    end
    $display("cfg act=%0d bs=%0d bp=%0d accepted_handshake=%0d", a, b, c, got);
  endtask

  // bad_idx < 0: tlast on the final beat; otherwise tlast only on bad_idx.
  task automatic send_beats(input int n, input int bad_idx, input int gap_pct);
    bit got;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 0;
        tick();
      end
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tlast  = (bad_idx < 0) ? (i == n - 1) : (i == bad_idx);
      s_axis_tvalid = 1;
      got = 0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge clk);
        got = s_axis_tready;
        tick();
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got tready=0 expected 1 within 50 cycles (beat %0d)", i);
        break;
      end
    end
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
    $display("stream %0d beats sent (tlast_idx=%0d gap=%0d%%)", n, bad_idx, gap_pct);
  endtask

  task automatic finish_tile(input int delay);
    bit seen;
    seen = 0;
    repeat (delay) tick();
    ld_tile_end = 1;
    tick();
    ld_tile_end = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = tile_done;
      tick();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL tile_done_timeout: got no tile_done expected pulse after ld_tile_end");
    end
    $display("tile end delay=%0d tile_done_seen=%0d", delay, seen);
  endtask

  initial begin
    int a0, w0, s0, d0;
    int ra, rb, rc, rbad;

    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    // 1: contiguous 4/2/3 tile
    a0 = n_act; w0 = n_wgt; d0 = n_done;
    do_cfg(4, 2, 3);
    @(negedge clk);
    chk("t1_start_at_T+1", ld_tile_start, 1'b1);
    tick();
    send_beats(9, -1, 0);
    finish_tile(0);
    chk("t1_act_beats", 64'(n_act - a0), 64'd4);
    chk("t1_wgt_beats", 64'(n_wgt - w0), 64'd5);
    chk("t1_tile_done", 64'(n_done - d0), 64'd1);
    chk("t1_err_cfg", err_cfg, 1'b0);
    chk("t1_err_tlast", err_tlast, 1'b0);

    // 2: same config with tvalid gaps
    a0 = n_act; w0 = n_wgt;
    do_cfg(4, 2, 3);
    send_beats(9, -1, 30);
    finish_tile(2);
    chk("t2_act_beats", 64'(n_act - a0), 64'd4);
    chk("t2_wgt_beats", 64'(n_wgt - w0), 64'd5);

    // 3: zero count rejected, then a minimal tile
    s0 = n_start;
    do_cfg(0, 2, 3);
    @(negedge clk);
    chk("t3_err_cfg", err_cfg, 1'b1);
    chk("t3_no_start", 64'(n_start - s0), 64'd0);
    tick();
    do_cfg(1, 1, 1);
    send_beats(3, -1, 0);
    finish_tile(1);
    chk("t3_starts", 64'(n_start - s0), 64'd1);

    // 4: early tlast on beat 7 (index 6)
    a0 = n_act; w0 = n_wgt;
    do_cfg(4, 2, 3);
    send_beats(9, 6, 0);
    finish_tile(3);
    chk("t4_err_tlast", err_tlast, 1'b1);
    chk("t4_all_beats", 64'(n_act - a0 + n_wgt - w0), 64'd9);

    // 5: reset during WGT beat 2, then a full-width activation count
    do_cfg(4, 2, 3);
    send_beats(5, -1, 0);
    rst = 1;
    s_axis_tvalid = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t5_err_cleared", {err_cfg, err_tlast}, 2'b00);
    chk("t5_times_cleared", bw_act_times, 16'd0);
    tick();
    a0 = n_act; w0 = n_wgt;
    do_cfg(65535, 1, 1);
    send_beats(65537, -1, 0);
    finish_tile(0);
    chk("t5_act_beats", 64'(n_act - a0), 64'd65535);
    chk("t5_wgt_beats", 64'(n_wgt - w0), 64'd2);
    chk("t5_err_tlast", err_tlast, 1'b0);

    // 6: back-to-back tiles with cfg_valid held
    do_cfg(2, 1, 2);
    cfg_act_times = 16'd1; cfg_bs_wgt_times = 16'd2; cfg_bp_wgt_times = 16'd1;
    cfg_valid = 1;
    send_beats(5, -1, 0);
    finish_tile(1);
    cfg_valid = 0;
    chk("t6_second_latched", bw_act_times, 16'd1);
    send_beats(4, -1, 0);
    finish_tile(0);

    // Random tiles
    for (int t = 0; t < 8; t++) begin
      ra = $urandom_range(4, 0);
      rb = $urandom_range(3, 1);
      rc = $urandom_range(3, 1);
      do_cfg(ra, rb, rc);
      if (ra != 0) begin
        rbad = ($urandom_range(3) == 0) ? $urandom_range(ra + rb + rc - 1) : -1;
        send_beats(ra + rb + rc, rbad, 30);
        finish_tile($urandom_range(3));
      end
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
